fetch_buffer: RTL and testbench

//  Downstream neighbour of the PC/IF stage. Drives the sync-read instruction memory with the current PC, pairs each

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/fetch_skid_reg.sv | 33 +++
 rtl/fetch_buffer.sv | 130 +++++++++++++
 tb/tb_fetch_buffer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: widths, NOP encoding and the IF->ID fetch packet.
// Also holds the fetch-buffer update-priority helper used by fetch_buffer.
package cpu_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 9'h000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_pkt_t;

    typedef enum logic [2:0] {
        UPD_RESET,
        UPD_FLUSH,
        UPD_DONE,
        UPD_STALL,
        UPD_NORMAL
    } upd_t;

    function automatic upd_t upd_sel(
        input logic rst_n,
        input logic flush,
        input logic done,
        input logic stall
    );
        upd_t r;
        if (!rst_n)     r = UPD_RESET;
        else if (flush) r = UPD_FLUSH;
        else if (done)  r = UPD_DONE;
        else if (stall) r = UPD_STALL;
        else            r = UPD_NORMAL;
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for a fetch packet caught behind a stall.
// Priority: clear > load > drain.
module fetch_skid_reg
    import cpu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_drain,
    input  fetch_pkt_t i_pkt,
    output fetch_pkt_t o_pkt,
    output logic       o_valid
);

    fetch_pkt_t r_pkt;
    logic       r_valid;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pkt   <= i_pkt;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_pkt   = r_pkt;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_buffer.sv
// Pairs sync-read imem data with its PC, skids across stalls, drops on flush.
// Optional FETCH_PERF_EN adds saturating bubble / flush counters.
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic               CLK,
    input  logic               Init_n,
    input  logic [PC_W-1:0]    PC,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               Done,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ID_instr,
    output logic [PC_W-1:0]    ID_pc,
    output logic               ID_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_bubbles,
    output logic [15:0]        perf_flushes
`endif
);

    logic               w_issue;
    upd_t               w_upd;
    fetch_pkt_t         w_f_pkt;
    fetch_pkt_t         w_skid_pkt;
    logic               w_skid_v;
    logic               w_skid_clr;
    logic               w_skid_load;
    logic               w_skid_drain;

    logic               r_f_v;
    logic [PC_W-1:0]    r_f_pc;
    logic [INSTR_W-1:0] r_id_instr;
    logic [PC_W-1:0]    r_id_pc;
    logic               r_id_valid;

    assign w_issue    = Init_n & ~Stall & ~Flush & ~Done;
    assign w_upd      = upd_sel(Init_n, Flush, Done, Stall);
    assign imem_addr  = PC;
    assign imem_rd_en = w_issue;

    assign w_f_pkt = '{instr: imem_data, pc: r_f_pc};

    // Issue is already low under reset/flush, so only Done needs a hold.
    always_ff @(posedge CLK) begin
        if (w_upd != UPD_DONE) begin
            r_f_pc <= PC;
            r_f_v  <= w_issue;
        end
    end

    assign w_skid_clr   = (w_upd == UPD_RESET) || (w_upd == UPD_FLUSH);
    assign w_skid_load  = (w_upd == UPD_STALL) && r_f_v;
    assign w_skid_drain = (w_upd == UPD_NORMAL) && w_skid_v;

    fetch_skid_reg u_skid (
        .i_clk   (CLK),
        .i_clear (w_skid_clr),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_pkt   (w_f_pkt),
        .o_pkt   (w_skid_pkt),
        .o_valid (w_skid_v)
    );

    always_ff @(posedge CLK) begin
        unique case (w_upd)
            UPD_RESET: begin
                r_id_valid <= 1'b0;
                r_id_instr <= NOP_INSTR;
                r_id_pc    <= '0;
            end
            UPD_FLUSH: r_id_valid <= 1'b0;
            UPD_NORMAL: begin
                if (w_skid_v) begin
                    r_id_valid <= 1'b1;
                    r_id_instr <= w_skid_pkt.instr;
                    r_id_pc    <= w_skid_pkt.pc;
                end else if (r_f_v) begin
                    r_id_valid <= 1'b1;
                    r_id_instr <= w_f_pkt.instr;
                    r_id_pc    <= w_f_pkt.pc;
                end else begin
                    r_id_valid <= 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ID_instr = r_id_instr;
    assign ID_pc    = r_id_pc;
    assign ID_valid = r_id_valid;

`ifdef FETCH_PERF_EN
    logic        w_bubble;
    logic [15:0] r_perf_bub;
    logic [15:0] r_perf_fl;

    assign w_bubble = (w_upd == UPD_FLUSH) ||
                      ((w_upd == UPD_NORMAL) && !w_skid_v && !r_f_v);

    always_ff @(posedge CLK) begin
        if (w_upd == UPD_RESET) begin
            r_perf_bub <= '0;
            r_perf_fl  <= '0;
        end else if (w_upd != UPD_DONE) begin
            if (w_bubble)
                r_perf_bub <= sat_inc(r_perf_bub);
            if (w_upd == UPD_FLUSH)
                r_perf_fl <= sat_inc(r_perf_fl);
        end
    end

    assign perf_bubbles = r_perf_bub;
    assign perf_flushes = r_perf_fl;
`endif

`ifndef SYNTHESIS
    // A second fetch may only land while the skid is full if decode is stalled.
    a_one_in_flight: assert property (
        @(posedge CLK) disable iff (!Init_n)
        !(r_f_v && w_skid_v && !Stall)
    );
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: issued PCs queue up, monitor pops.
// Random IF-stage stimulus after a directed prologue.
module tb_fetch_buffer;
    import cpu_pkg::*;

    logic               CLK = 1'b0;
    logic               Init_n;
    logic [PC_W-1:0]    PC;
    logic               Stall;
    logic               Flush;
    logic               Done;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] ID_instr;
    logic [PC_W-1:0]    ID_pc;
    logic               ID_valid;
`ifdef FETCH_PERF_EN
    logic [15:0]        perf_bubbles;
    logic [15:0]        perf_flushes;
`endif

    fetch_buffer dut (
        .CLK        (CLK),
        .Init_n     (Init_n),
        .PC         (PC),
        .Stall      (Stall),
        .Flush      (Flush),
        .Done       (Done),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_data  (imem_data),
        .ID_instr   (ID_instr),
        .ID_pc      (ID_pc),
`ifdef FETCH_PERF_EN
        .perf_bubbles (perf_bubbles),
        .perf_flushes (perf_flushes),
`endif
        .ID_valid   (ID_valid)
    );

    always #5 CLK = ~CLK;

    logic [INSTR_W-1:0] mem [1024];

    always @(posedge CLK)
        if (imem_rd_en) imem_data <= mem[imem_addr];

    typedef struct {
        logic [PC_W-1:0] pc;
        int              e;
    } iss_t;

    iss_t            q[$];
    int              checks = 0;
    int              errs   = 0;
    int              edge_cnt = 0;
    logic [PC_W-1:0] pc_cur;

    logic               ev;
    logic [PC_W-1:0]    ep;
    logic [INSTR_W-1:0] ei;
    int                 m_bub;
    int                 m_fl;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at edge %0d: got %0h want %0h",
                     nm, edge_cnt, act, exp);
        end
    endtask

    // Monitor: classify each edge from sampled inputs, update expectation.
    initial begin
        logic s_rn, s_st, s_fl, s_dn;
        iss_t p;
        forever begin
            @(posedge CLK);
            s_rn = Init_n;
            s_st = Stall;
            s_fl = Flush;
            s_dn = Done;
            edge_cnt++;
            if (s_rn !== 1'b1) begin
                q.delete();
                ev = 1'b0; ep = '0; ei = NOP_INSTR;
                m_bub = 0; m_fl = 0;
            end else if (s_fl) begin
                q.delete();
                ev = 1'b0;
                if (m_bub < 16'hFFFF) m_bub++;
                if (m_fl < 16'hFFFF) m_fl++;
            end else if (s_dn || s_st) begin
            end else if (q.size() > 0 && q[0].e < edge_cnt) begin
                p  = q.pop_front();
                ev = 1'b1;
                ep = p.pc;
                ei = mem[p.pc];
            end else begin
                ev = 1'b0;
                if (m_bub < 16'hFFFF) m_bub++;
            end
            #1;
            chk("id_valid", 32'(ID_valid), 32'(ev));
            chk("id_pc", 32'(ID_pc), 32'(ep));
            chk("id_instr", 32'(ID_instr), 32'(ei));
`ifdef FETCH_PERF_EN
            chk("perf_bubbles", 32'(perf_bubbles), m_bub);
            chk("perf_flushes", 32'(perf_flushes), m_fl);
`endif
        end
    end

    task automatic cyc(input logic rn, input logic st,
                       input logic fl, input logic dn,
                       input logic [PC_W-1:0] tgt);
        logic iss;
        @(negedge CLK);
        Init_n = rn; Stall = st; Flush = fl; Done = dn;
        PC = pc_cur;
        iss = rn & ~st & ~fl & ~dn;
        if (iss) q.push_back('{pc: pc_cur, e: edge_cnt + 1});
        #1;
        chk("imem_rd_en", 32'(imem_rd_en), 32'(iss));
        chk("imem_addr", 32'(imem_addr), 32'(pc_cur));
        @(posedge CLK);
        if (!rn)       pc_cur = '0;
        else if (fl)   pc_cur = tgt;
        else if (iss)  pc_cur = pc_cur + 1'b1;
    endtask

    task automatic run(input int n, input logic st, input logic dn);
        for (int i = 0; i < n; i++) cyc(1'b1, st, 1'b0, dn, '0);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++)
            mem[a] = (a < 16) ? INSTR_W'(9'h100 + a)
                              : INSTR_W'($urandom);
        imem_data = '0;
        Init_n = 1'b0; Stall = 1'b0; Flush = 1'b0; Done = 1'b0;
        pc_cur = '0; PC = '0;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        run(6, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd32);
        run(4, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd40);
        run(3, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
        run(4, 1'b0, 1'b0);
        run(3, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd1021);
        run(6, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd50);
        run(3, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic rn, st, fl, dn;
            rn = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 99) < 25);
            fl = ($urandom_range(0, 99) < 8);
            dn = ($urandom_range(0, 99) < 5);
            cyc(rn, st, fl, dn, PC_W'($urandom));
        end
        run(4, 1'b0, 1'b0);

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errs);
        $finish;
    end

endmodule
